// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: state encoding and
// width helpers for the owner index and beat counter.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } arb_state_t;

   // Owner index width; a single-bit index is kept even for degenerate counts.
   function automatic int id_w(input int n_req);
      return (n_req > 1) ? $clog2(n_req) : 1;
   endfunction

   function automatic int cnt_w(input int max_burst);
      return $clog2(max_burst + 1);
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotate-priority finder: returns the first set request at or after ptr,
// wrapping N_REQ-1 -> 0.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]        req,
   input  logic [id_w(N_REQ)-1:0]  ptr,
   output logic [id_w(N_REQ)-1:0]  idx,
   output logic                    valid
);

   localparam int ID_W = id_w(N_REQ);

   int pos;

   // Scan from farthest to nearest so the nearest set bit is written last.
   // NOTE: every variable gets a default before the loop so no latch is inferred.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      pos   = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         pos = int'(ptr) + k;
         if (pos >= N_REQ) pos = pos - N_REQ;
         if (req[pos]) begin
            idx   = ID_W'(pos);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin owner of the FIFO write port: one requester holds the port for
// up to MAX_BURST accepted beats, stalling on wfull without losing its slot.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*WIDTH-1:0]   req_data,
   output logic [N_REQ-1:0]         gnt,
   input  logic                     fifo_wfull,
   output logic                     fifo_winc,
   output logic [WIDTH-1:0]         fifo_wdata,
   output logic [id_w(N_REQ)-1:0]   owner_id,
   output logic                     busy
);

   localparam int ID_W  = id_w(N_REQ);
   localparam int CNT_W = cnt_w(MAX_BURST);

   arb_state_t        state, state_nxt;
   logic [ID_W-1:0]   rr_ptr;
   logic [CNT_W-1:0]  beat_cnt;
   logic [ID_W-1:0]   pick_idx;
   logic              pick_valid;
   logic              owner_req;
   logic [WIDTH-1:0]  owner_data;
   logic              last_beat;
   logic              release_own;
   logic [ID_W-1:0]   ptr_after_owner;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req   (req),
      .ptr   (rr_ptr),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   always_comb begin
      owner_req  = 1'b0;
      owner_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (owner_id == ID_W'(i)) begin
            owner_req  = req[i];
            owner_data = req_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign last_beat       = fifo_winc && (beat_cnt == CNT_W'(MAX_BURST - 1));
   assign release_own     = last_beat || !owner_req;
   assign ptr_after_owner = (owner_id == ID_W'(N_REQ - 1)) ? '0 : owner_id + 1'b1;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_valid)  state_nxt = OWN;
         OWN:     if (release_own) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state == OWN);
      fifo_winc  = busy && owner_req && !fifo_wfull;
      gnt        = fifo_winc ? (N_REQ'(1) << owner_id) : '0;
      fifo_wdata = fifo_winc ? owner_data : '0;
   end

   // Owner, rotation pointer and beat count; a wfull stall simply holds them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr   <= '0;
         owner_id <= '0;
         beat_cnt <= '0;
      end else if (state == IDLE) begin
         if (pick_valid) begin
            owner_id <= pick_idx;
            beat_cnt <= '0;
         end
      end else if (release_own) begin
         rr_ptr   <= ptr_after_owner;
         beat_cnt <= '0;
      end else if (fifo_winc) begin
         beat_cnt <= beat_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a 4-requester/4-beat instance plus a
// 3-requester single-beat instance for wrap and MAX_BURST=1 behaviour.
module tb_fifo_wr_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  gnt;
   logic        fifo_wfull;
   logic        fifo_winc;
   logic [7:0]  fifo_wdata;
   logic [1:0]  owner_id;
   logic        busy;

   logic [2:0]  req2;
   logic [23:0] req_data2;
   logic [2:0]  gnt2;
   logic        winc2;
   logic [7:0]  wdata2;
   logic [1:0]  owner2;
   logic        busy2;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_BURST(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_data   (req_data),
      .gnt        (gnt),
      .fifo_wfull (fifo_wfull),
      .fifo_winc  (fifo_winc),
      .fifo_wdata (fifo_wdata),
      .owner_id   (owner_id),
      .busy       (busy)
   );

   fifo_wr_arbiter #(.N_REQ(3), .WIDTH(8), .MAX_BURST(1)) dut2 (
      .clk        (clk),
      .rst        (rst),
      .req        (req2),
      .req_data   (req_data2),
      .gnt        (gnt2),
      .fifo_wfull (1'b0),
      .fifo_winc  (winc2),
      .fifo_wdata (wdata2),
      .owner_id   (owner2),
      .busy       (busy2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_slot(input int i, input logic [7:0] v);
      req_data[i*8 +: 8] = v;
   endtask

   // Check one cycle of the main instance at the falling edge, then advance.
   task automatic exp_cycle(input string tag, input logic winc, input int o,
                            input logic [7:0] d, input logic bz);
      @(negedge clk);
      check({tag, ".winc"},  32'(fifo_winc), 32'(winc));
      check({tag, ".gnt"},   32'(gnt), winc ? (32'd1 << o) : 32'd0);
      check({tag, ".wdata"}, 32'(fifo_wdata), winc ? 32'(d) : 32'd0);
      check({tag, ".busy"},  32'(busy), 32'(bz));
      if (bz) check({tag, ".owner"}, 32'(owner_id), 32'(o));
      step();
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      logic [7:0] d;
      int owners [5];
      int owners2 [4];
      owners  = '{0, 1, 2, 3, 0};
      owners2 = '{0, 1, 2, 0};

      rst        = 1'b1;
      req        = '0;
      req_data   = '0;
      fifo_wfull = 1'b0;
      req2       = '0;
      req_data2  = {8'h33, 8'h22, 8'h11};

      // Reset, then quiet idle
      repeat (3) step();
      check("rst.winc",  32'(fifo_winc), 0);
      check("rst.gnt",   32'(gnt), 0);
      check("rst.wdata", 32'(fifo_wdata), 0);
      check("rst.owner", 32'(owner_id), 0);
      check("rst.busy",  32'(busy), 0);
      rst = 1'b0;
      for (int c = 0; c < 20; c++) exp_cycle("idle", 1'b0, 0, 8'h00, 1'b0);

      // Single requester: two 4-beat bursts separated by one IDLE cycle
      req = 4'b0010;
      d   = 8'hA0;
      set_slot(1, d);
      for (int b = 0; b < 2; b++) begin
         exp_cycle("single.arb", 1'b0, 1, 8'h00, 1'b0);
         for (int k = 0; k < 4; k++) begin
            exp_cycle("single.beat", 1'b1, 1, d, 1'b1);
            d = d + 8'h01;
            set_slot(1, d);
         end
      end
      req = 4'b0000;
      exp_cycle("single.end", 1'b0, 1, 8'h00, 1'b0);

      // Round-robin rotation with all four requesting
      pulse_reset();
      req_data = {8'h44, 8'h33, 8'h22, 8'h11};
      req      = 4'b1111;
      foreach (owners[j]) begin
         exp_cycle("rr.arb", 1'b0, owners[j], 8'h00, 1'b0);
         for (int k = 0; k < 4; k++)
            exp_cycle("rr.beat", 1'b1, owners[j], 8'(8'h11 * (owners[j] + 1)), 1'b1);
      end

      // Backpressure stall of owner 2 after two beats
      req = 4'b0000;
      pulse_reset();
      req = 4'b0100;
      d   = 8'hC0;
      set_slot(2, d);
      exp_cycle("bp.arb", 1'b0, 2, 8'h00, 1'b0);
      for (int k = 0; k < 2; k++) begin
         exp_cycle("bp.pre", 1'b1, 2, d, 1'b1);
         d = d + 8'h01;
         set_slot(2, d);
      end
      fifo_wfull = 1'b1;
      for (int k = 0; k < 5; k++) exp_cycle("bp.stall", 1'b0, 2, 8'h00, 1'b1);
      fifo_wfull = 1'b0;
      for (int k = 0; k < 2; k++) begin
         exp_cycle("bp.post", 1'b1, 2, d, 1'b1);
         d = d + 8'h01;
         set_slot(2, d);
      end
      // rr_ptr must now be 3: with 0, 2 and 3 requesting, 3 wins
      req = 4'b1101;
      set_slot(3, 8'hE5);
      exp_cycle("bp.rearb", 1'b0, 3, 8'h00, 1'b0);
      exp_cycle("bp.next", 1'b1, 3, 8'hE5, 1'b1);

      // Early release by owner 0 after one beat
      req = 4'b0000;
      pulse_reset();
      req = 4'b1001;
      set_slot(0, 8'hD0);
      set_slot(3, 8'hE0);
      exp_cycle("early.arb", 1'b0, 0, 8'h00, 1'b0);
      exp_cycle("early.beat", 1'b1, 0, 8'hD0, 1'b1);
      req = 4'b1000;
      exp_cycle("early.drop", 1'b0, 0, 8'h00, 1'b1);
      req = 4'b1001;
      exp_cycle("early.idle", 1'b0, 0, 8'h00, 1'b0);
      exp_cycle("early.next", 1'b1, 3, 8'hE0, 1'b1);

      // Asynchronous reset during owner 3's burst (beat_cnt=1)
      #2 rst = 1'b1;
      #1;
      check("arst.winc",  32'(fifo_winc), 0);
      check("arst.gnt",   32'(gnt), 0);
      check("arst.wdata", 32'(fifo_wdata), 0);
      check("arst.owner", 32'(owner_id), 0);
      check("arst.busy",  32'(busy), 0);
      step();
      req = 4'b1000;
      rst = 1'b0;
      exp_cycle("arst.arb", 1'b0, 3, 8'h00, 1'b0);
      for (int k = 0; k < 4; k++) exp_cycle("arst.beat", 1'b1, 3, 8'hE0, 1'b1);
      req = 4'b0000;
      exp_cycle("arst.end", 1'b0, 3, 8'h00, 1'b0);

      // MAX_BURST=1 with three requesters: one beat each, wrap 2 -> 0
      req2 = 3'b111;
      foreach (owners2[j]) begin
         @(negedge clk);
         check("mb1.idle.winc", 32'(winc2), 0);
         check("mb1.idle.busy", 32'(busy2), 0);
         step();
         @(negedge clk);
         check("mb1.winc",  32'(winc2), 1);
         check("mb1.gnt",   32'(gnt2), 32'd1 << owners2[j]);
         check("mb1.owner", 32'(owner2), 32'(owners2[j]));
         check("mb1.wdata", 32'(wdata2), 32'(8'h11 * (owners2[j] + 1)));
         step();
      end
      req2 = 3'b000;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
